// File: rtl/schem_stim_seq.sv
// schem_stim_seq: steps a 4-bit stimulus through all vectors, settles, and checks an AND-OR datapath
module schem_stim_seq #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              dut_out,
  output logic [3:0]        dut_in,
  output logic              busy,
  output logic              done,
  output logic [4:0]        err_count,
  output logic              fail_valid,
  output logic [3:0]        first_fail
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [HOLD_W-1:0] h_q, h_d, cnt_q, cnt_d, hold_eff;
  logic [3:0] vec_q, vec_d, ff_q, ff_d;
  logic [4:0] err_q, err_d;
  logic fv_q, fv_d, exp_v, mis;
  assign hold_eff = hold_cycles == '0 ? HOLD_W'(1) : hold_cycles;
  assign exp_v = (vec_q[0] & vec_q[1]) | (vec_q[2] & vec_q[3]);
  assign mis = dut_out != exp_v;
  // state register; reset abandons any run immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: abort only matters while a run is active, start only in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = start ? SETTLE : IDLE;
      SETTLE: state_d = abort ? IDLE : cnt_q == HOLD_W'(1) ? CHECK : SETTLE;
      CHECK:  state_d = abort ? IDLE : vec_q == 4'hf ? DONE : SETTLE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // status outputs decoded from state
  always_comb begin
    busy = state_q == SETTLE || state_q == CHECK;
    done = state_q == DONE;
  end
  // datapath next values: hold count, vector stepping, and mismatch bookkeeping
  always_comb begin
    h_d = h_q;
    cnt_d = cnt_q;
    vec_d = vec_q;
    err_d = err_q;
    fv_d = fv_q;
    ff_d = ff_q;
    case (state_q)
      IDLE: if (start) begin
        h_d = hold_eff;
        cnt_d = hold_eff;
        vec_d = '0;
        err_d = '0;
        fv_d = 1'b0;
        ff_d = '0;
      end
      SETTLE: begin
        vec_d = abort ? 4'd0 : vec_q;
        cnt_d = abort ? cnt_q : cnt_q - HOLD_W'(1);
      end
      CHECK: if (abort) vec_d = '0;
      else begin
        err_d = mis ? err_q + 5'd1 : err_q;
        fv_d = fv_q | mis;
        ff_d = mis && !fv_q ? vec_q : ff_q;
        vec_d = vec_q == 4'hf ? vec_q : vec_q + 4'd1;
        cnt_d = vec_q == 4'hf ? cnt_q : h_q;
      end
      DONE: vec_d = '0;
      default: vec_d = '0;
    endcase
  end
  // datapath registers; results survive abort and idle until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      cnt_q <= '0;
      vec_q <= '0;
      err_q <= '0;
      fv_q <= 1'b0;
      ff_q <= '0;
    end else begin
      h_q <= h_d;
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      err_q <= err_d;
      fv_q <= fv_d;
      ff_q <= ff_d;
    end
  end
  assign dut_in = vec_q;
  assign err_count = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;
endmodule

// File: tb/tb_schem_stim_seq.sv
// tb_schem_stim_seq: scoreboard bench for the stimulus sequencer driving a modelled AND-OR datapath
module tb_schem_stim_seq;
  logic clk = 0, rst = 0, start = 0, abort = 0;
  logic [3:0] hold_cycles = 0;
  logic dut_out, busy, done, fail_valid;
  logic [3:0] dut_in, first_fail;
  logic [4:0] err_count;
  int mode = 0;
  typedef struct {int cyc; int err; int fv; int ff;} res_t;
  res_t rq[$];
  res_t r;
  int vq[$];
  int busy_n = 0, n_chk = 0, n_fail = 0;

  schem_stim_seq #(.HOLD_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold_cycles(hold_cycles),
    .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done),
    .err_count(err_count), .fail_valid(fail_valid), .first_fail(first_fail)
  );

  always #5 clk = ~clk;

  function automatic logic ref_f(logic [3:0] v);
    return (v[0] & v[1]) | (v[2] & v[3]);
  endfunction

  assign dut_out = mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : ref_f(dut_in);

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(int hold, int m, int with_abort);
    int h, e, fv, ff;
    logic o;
    h = hold == 0 ? 1 : hold;
    e = 0; fv = 0; ff = 0;
    mode = m;
    for (int v = 0; v < 16; v++) begin
      o = m == 1 ? 1'b0 : m == 2 ? 1'b1 : ref_f(4'(v));
      if (o != ref_f(4'(v))) begin
        if (fv == 0) begin fv = 1; ff = v; end
        e++;
      end
      repeat (h + 1) vq.push_back(v);
    end
    rq.push_back('{16 * (h + 1), e, fv, ff});
    hold_cycles = 4'(hold);
    start = 1;
    abort = 1'(with_abort);
    tick;
    start = 0;
    abort = 0;
    hold_cycles = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done;
    logic ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk("done_seen", ok, 1);
    tick;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_dut_in", dut_in, 0);
  endtask

  always @(negedge clk) if (!rst) begin
    if (busy) begin
      busy_n++;
      chk("dut_in", dut_in, vq.size() != 0 ? vq.pop_front() : 99);
    end
    if (done) begin
      if (rq.size() == 0) chk("unexpected_done", done, 0);
      else begin
        r = rq.pop_front();
        chk("busy_cycles", busy_n, r.cyc);
        chk("err_count", err_count, r.err);
        chk("fail_valid", fail_valid, r.fv);
        if (r.fv != 0) chk("first_fail", first_fail, r.ff);
      end
      busy_n = 0;
    end
  end

  initial begin
    logic seen;
    #1 rst = 1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fv", fail_valid, 0);
    chk("rst_ff", first_fail, 0);
    tick; tick;
    rst = 0;
    tick;
    launch(1, 0, 0); wait_done;
    launch(1, 1, 0); wait_done;
    repeat (3) tick;
    chk("idle_err_stable", err_count, 7);
    chk("idle_ff_stable", first_fail, 3);
    launch(1, 2, 0); wait_done;
    launch(0, 0, 0); wait_done;
    launch(3, 0, 0); wait_done;
    launch(2, 0, 0);
    repeat (10) tick;
    hold_cycles = 9; start = 1;
    tick;
    start = 0;
    wait_done;
    launch(1, 0, 1); wait_done;
    launch(2, 1, 0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dut_in == 5) begin seen = 1; break; end
    end
    chk("reach_vec5", seen, 1);
    @(posedge clk); #1;
    abort = 1;
    tick;
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dut_in", dut_in, 0);
    chk("abort_err", err_count, 1);
    chk("abort_fv", fail_valid, 1);
    chk("abort_ff", first_fail, 3);
    vq.delete(); rq.delete(); busy_n = 0;
    repeat (4) tick;
    chk("abort_err_kept", err_count, 1);
    launch(3, 1, 0);
    repeat (10) tick;
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_dut_in", dut_in, 0);
    chk("arst_err", err_count, 0);
    chk("arst_fv", fail_valid, 0);
    chk("arst_ff", first_fail, 0);
    @(posedge clk); #1;
    rst = 0;
    vq.delete(); rq.delete(); busy_n = 0;
    tick;
    launch(2, 0, 0); wait_done;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
